// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with vector fetch, interrupt latching and return-address stack
module pc_unit #(
    parameter int ADDR_W         = 8,
    parameter int RAS_DEPTH      = 4,
    parameter int RESET_VEC_ADDR = 0,
    parameter int INT_VEC_ADDR   = 1,
    localparam int CW            = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic              rti_i,
    input  logic              irq_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic [ADDR_W-1:0] mem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    output logic              vec_fetch_o,
    output logic              int_active_o,
    output logic [CW-1:0]     ras_count_o,
    output logic              ras_ovf_o,
    output logic              ras_unf_o
);

    localparam logic [ADDR_W-1:0] RST_VEC = ADDR_W'(RESET_VEC_ADDR);
    localparam logic [ADDR_W-1:0] INT_VEC = ADDR_W'(INT_VEC_ADDR);

    typedef enum logic [1:0] {
        ST_RVEC,
        ST_IVEC,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              int_active_q, int_active_d;
    logic              irq_pending_q, irq_pending_d;
    logic [CW-1:0]     ras_cnt_q, ras_cnt_d;
    logic              ras_ovf_q, ras_ovf_d;
    logic              ras_unf_q, ras_unf_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pop_val;
    logic [ADDR_W-1:0] push_val;
    logic              push_req;
    logic              push_en;
    logic              took;
    logic              take;
    logic              ras_full;
    logic              ras_empty;

    // Next-state selection: vector loads, control-transfer priority, RAS push/pop and irq latching
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        int_active_d  = int_active_q;
        irq_pending_d = irq_pending_q;
        ras_cnt_d     = ras_cnt_q;
        ras_ovf_d     = ras_ovf_q;
        ras_unf_d     = ras_unf_q;
        push_req      = 1'b0;
        push_en       = 1'b0;
        push_val      = pc_q;
        took          = 1'b0;
        pop_val       = '0;
        pc_inc        = pc_q + ADDR_W'(1);
        ras_full      = (ras_cnt_q == CW'(RAS_DEPTH));
        ras_empty     = (ras_cnt_q == '0);
        take          = (irq_i | irq_pending_q) & ~int_active_q;

        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (CW'(i) == ras_cnt_q - CW'(1)) begin
                pop_val = ras_q[i];
            end
        end

        if (!stall_i) begin
            unique case (state_q)
                ST_RVEC: begin
                    pc_d    = mem_data_i;
                    state_d = ST_RUN;
                end
                ST_IVEC: begin
                    pc_d         = mem_data_i;
                    int_active_d = 1'b1;
                    state_d      = ST_RUN;
                end
                ST_RUN: begin
                    if (rti_i || ret_i) begin
                        if (rti_i) begin
                            int_active_d = 1'b0;
                        end
                        if (ras_empty) begin
                            ras_unf_d = 1'b1;
                            pc_d      = pc_inc;
                        end else begin
                            pc_d      = pop_val;
                            ras_cnt_d = ras_cnt_q - CW'(1);
                        end
                    end else if (call_i) begin
                        push_req = 1'b1;
                        push_val = pc_inc;
                        pc_d     = branch_addr_i;
                    end else if (branch_taken_i) begin
                        pc_d = branch_addr_i;
                    end else if (take) begin
                        // Push the current pc so the interrupted instruction is re-fetched on rti
                        push_req = 1'b1;
                        push_val = pc_q;
                        pc_d     = INT_VEC;
                        took     = 1'b1;
                        state_d  = ST_IVEC;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                default: state_d = ST_RVEC;
            endcase
        end

        // A full stack drops the push but the jump itself still happens
        if (push_req) begin
            if (ras_full) begin
                ras_ovf_d = 1'b1;
            end else begin
                push_en   = 1'b1;
                ras_cnt_d = ras_cnt_q + CW'(1);
            end
        end

        // irq is remembered whenever it is not consumed on this edge, even while stalled
        if (took) begin
            irq_pending_d = 1'b0;
        end else if (irq_i) begin
            irq_pending_d = 1'b1;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RVEC;
            pc_q          <= RST_VEC;
            int_active_q  <= 1'b0;
            irq_pending_q <= 1'b0;
            ras_cnt_q     <= '0;
            ras_ovf_q     <= 1'b0;
            ras_unf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            int_active_q  <= int_active_d;
            irq_pending_q <= irq_pending_d;
            ras_cnt_q     <= ras_cnt_d;
            ras_ovf_q     <= ras_ovf_d;
            ras_unf_q     <= ras_unf_d;
        end
    end

    // Return-address storage; entries above the count are don't-care so no reset is needed
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (!rst_i && push_en && (CW'(i) == ras_cnt_q)) begin
                ras_q[i] <= push_val;
            end
        end
    end

    assign pc_o         = pc_q;
    assign valid_o      = (state_q == ST_RUN);
    assign vec_fetch_o  = (state_q != ST_RUN);
    assign int_active_o = int_active_q;
    assign ras_count_o  = ras_cnt_q;
    assign ras_ovf_o    = ras_ovf_q;
    assign ras_unf_o    = ras_unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - table-driven self-checking bench for pc_unit
module tb_pc_unit;

    localparam int AW = 8;
    localparam int CW = 3;

    // control bit masks: {rst, stall, branch, call, ret, rti, irq}
    localparam logic [6:0] N  = 7'b0000000;
    localparam logic [6:0] R  = 7'b1000000;
    localparam logic [6:0] S  = 7'b0100000;
    localparam logic [6:0] B  = 7'b0010000;
    localparam logic [6:0] C  = 7'b0001000;
    localparam logic [6:0] RT = 7'b0000100;
    localparam logic [6:0] RI = 7'b0000010;
    localparam logic [6:0] Q  = 7'b0000001;

    typedef struct {
        logic [6:0]  ctl;
        logic [7:0]  ba;
        logic [7:0]  md;
        logic [15:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, stall, br, call, ret, rti, irq;
    logic [AW-1:0] ba, md;
    logic [AW-1:0] pc;
    logic          valid, vec_fetch, int_active, ovf, unf;
    logic [CW-1:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    pc_unit #(.ADDR_W(AW), .RAS_DEPTH(4), .RESET_VEC_ADDR(0), .INT_VEC_ADDR(1)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_taken_i(br),
        .call_i(call), .ret_i(ret), .rti_i(rti), .irq_i(irq),
        .branch_addr_i(ba), .mem_data_i(md),
        .pc_o(pc), .valid_o(valid), .vec_fetch_o(vec_fetch), .int_active_o(int_active),
        .ras_count_o(cnt), .ras_ovf_o(ovf), .ras_unf_o(unf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] c, input logic [7:0] a, input logic [7:0] m,
                                input logic [7:0] epc, input logic ev, input logic evf,
                                input logic eia, input logic [2:0] ecnt, input logic eo,
                                input logic eu);
        vec_t v;
        v.ctl = c;
        v.ba  = a;
        v.md  = m;
        v.exp = {epc, ev, evf, eia, ecnt, eo, eu};
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [15:0] act;
        @(negedge clk);
        {rst, stall, br, call, ret, rti, irq} = v.ctl;
        ba = v.ba;
        md = v.md;
        @(posedge clk);
        #1;
        act = {pc, valid, vec_fetch, int_active, cnt, ovf, unf};
        n_cmp++;
        if (act !== v.exp) begin
            n_bad++;
            $display("FAIL %s: got pc=%h v=%b vf=%b ia=%b cnt=%0d ovf=%b unf=%b, want pc=%h v=%b vf=%b ia=%b cnt=%0d ovf=%b unf=%b",
                     name, act[15:8], act[7], act[6], act[5], act[4:2], act[1], act[0],
                     v.exp[15:8], v.exp[7], v.exp[6], v.exp[5], v.exp[4:2], v.exp[1], v.exp[0]);
        end
    endtask

    initial begin
        {rst, stall, br, call, ret, rti, irq} = 7'b1000000;
        ba = '0;
        md = '0;

        //                ctl     ba     md      pc     v  vf ia cnt o  u
        tbl.push_back(mk(R,      8'h00, 8'h40, 8'h00, 0, 1, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(R,      8'h00, 8'h40, 8'h00, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(N,      8'h00, 8'h40, 8'h40, 1, 0, 0, 0, 0, 0)); // boot vector
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h41, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h42, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C,      8'h80, 8'h00, 8'h80, 1, 0, 0, 1, 0, 0)); // call
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h81, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h82, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(RT,     8'h00, 8'h00, 8'h43, 1, 0, 0, 0, 0, 0)); // ret
        tbl.push_back(mk(B,      8'h50, 8'h00, 8'h50, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(Q,      8'h00, 8'h00, 8'h01, 0, 1, 0, 1, 0, 0)); // irq taken
        tbl.push_back(mk(N,      8'h00, 8'hC0, 8'hC0, 1, 0, 1, 1, 0, 0)); // handler
        tbl.push_back(mk(Q,      8'h00, 8'h00, 8'hC1, 1, 0, 1, 1, 0, 0)); // irq pends
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'hC2, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(RI,     8'h00, 8'h00, 8'h50, 1, 0, 0, 0, 0, 0)); // rti
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h01, 0, 1, 0, 1, 0, 0)); // pending taken
        tbl.push_back(mk(N,      8'h00, 8'hD0, 8'hD0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(RI,     8'h00, 8'h00, 8'h50, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B,      8'h60, 8'h00, 8'h60, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B|Q,    8'h90, 8'h00, 8'h90, 1, 0, 0, 0, 0, 0)); // branch beats irq
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h01, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(S,      8'h00, 8'hAA, 8'h01, 0, 1, 0, 1, 0, 0)); // stall in IVEC
        tbl.push_back(mk(S,      8'h00, 8'hAA, 8'h01, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(N,      8'h00, 8'hA0, 8'hA0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(RI,     8'h00, 8'h00, 8'h90, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C,      8'h70, 8'h00, 8'h70, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(Q,      8'h00, 8'h00, 8'h01, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(R|S|Q,  8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0)); // rst in IVEC
        tbl.push_back(mk(N,      8'h00, 8'h10, 8'h10, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h11, 1, 0, 0, 0, 0, 0)); // no stale pending
        tbl.push_back(mk(S|C,    8'h33, 8'h00, 8'h11, 1, 0, 0, 0, 0, 0)); // stall in RUN
        tbl.push_back(mk(S|Q,    8'h00, 8'h00, 8'h11, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(N,      8'h00, 8'h00, 8'h01, 0, 1, 0, 1, 0, 0)); // irq latched in stall
        tbl.push_back(mk(N,      8'h00, 8'hE0, 8'hE0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(RI,     8'h00, 8'h00, 8'h11, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // nested calls past the stack depth, then unwind one past empty
        begin
            logic [7:0] tgt [5] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
            logic [7:0] rets [4] = '{8'h41, 8'h31, 8'h21, 8'h12};
            for (int k = 0; k < 5; k++) begin
                apply(mk(C, tgt[k], 8'h00, tgt[k], 1, 0, 0, (k < 4) ? 3'(k + 1) : 3'd4,
                         (k == 4), 0), $sformatf("call%0d", k));
            end
            for (int k = 0; k < 4; k++) begin
                apply(mk(RT, 8'h00, 8'h00, rets[k], 1, 0, 0, 3'(3 - k), 1, 0),
                      $sformatf("ret%0d", k));
            end
            apply(mk(RT, 8'h00, 8'h00, 8'h13, 1, 0, 0, 0, 1, 1), "ret_unf");
            apply(mk(RI, 8'h00, 8'h00, 8'h14, 1, 0, 0, 0, 1, 1), "rti_unf");
        end

        // sequential wrap and final reset clearing sticky flags
        apply(mk(B, 8'hFF, 8'h00, 8'hFF, 1, 0, 0, 0, 1, 1), "to_ff");
        apply(mk(N, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 1, 1), "wrap");
        apply(mk(R, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0), "rst_flags");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined processor's fetch stage. It owns the PC register, selects the next fetch address from sequential, branch, call, return and interrupt sources, and fetches reset and interrupt vectors from instruction memory through a small state machine. It also holds a hardware return-address stack (RAS) shared by call/ret and interrupt entry/exit. It generalises the 8-bit next-PC mux to any address width and adds stall, vector fetch, pending-interrupt latching and RAS buffering.

## Interface
- ADDR_W, 8: PC and address width.
- RAS_DEPTH, 4: return-address stack entries (≥1).
- RESET_VEC_ADDR, 0: memory location holding the reset vector.
- INT_VEC_ADDR, 1: memory location holding the interrupt vector.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all state except irq_pending.
- branch_taken  in  1  jump to branch_addr.
- call  in  1  push pc+1, jump to branch_addr.
- ret  in  1  pop RAS into pc.
- rti  in  1  pop RAS into pc, clear int_active.
- irq  in  1  interrupt request (pulse or level).
- branch_addr  in  ADDR_W  branch/call target.
- mem_data  in  ADDR_W  combinational instruction-memory read data at address pc.
- pc  out  ADDR_W  registered fetch address.
- valid  out  1  pc is a real instruction fetch.
- vec_fetch  out  1  pc addresses a vector location; mem_data consumed.
- int_active  out  1  inside interrupt handler.
- ras_count  out  $clog2(RAS_DEPTH+1)  RAS occupancy.
- ras_ovf  out  1  sticky: push attempted while full.
- ras_unf  out  1  sticky: pop attempted while empty.

## Operation
- States: RVEC, IVEC, RUN. valid=1 only in RUN; vec_fetch=1 in RVEC/IVEC.
- RVEC: pc=RESET_VEC_ADDR; next unstalled edge pc<=mem_data, ->RUN.
- IVEC: pc=INT_VEC_ADDR; next unstalled edge pc<=mem_data, int_active<=1, ->RUN.
- RUN, unstalled, priority highest first:
  - rti: pc<=pop, int_active<=0.
  - ret: pc<=pop.
  - call: push pc+1 (mod 2^ADDR_W), pc<=branch_addr.
  - branch_taken: pc<=branch_addr.
  - take = (irq|irq_pending) & !int_active: push pc (the instruction at pc is re-fetched after rti), pc<=INT_VEC_ADDR, irq_pending<=0, ->IVEC.
  - otherwise pc<=pc+1, wrapping all-ones to 0.
- irq_pending is set on any edge with irq=1 that does not take the interrupt (stall, control transfer, int_active, vector state). It is cleared only when the interrupt is taken or by rst. No nesting.
- RAS is LIFO. Push when full: push dropped, ras_ovf<=1, jump still performed. Pop when empty: ras_unf<=1, pc<=pc+1, int_active still cleared on rti.
- stall=1: pc, state, RAS, int_active and flags all hold, in every state.

## Timing
- Reset values (edge with rst=1): pc=RESET_VEC_ADDR, state RVEC, valid=0, vec_fetch=1, int_active=0, irq_pending=0, ras_count=0, ras_ovf=0, ras_unf=0. rst overrides stall and all other inputs, including in the middle of IVEC.
- Boot: first valid fetch appears 1 unstalled cycle after reset deasserts.
- Interrupt latency: 2 edges from the take edge to the first handler fetch (IVEC, then vector address).
- All outputs are registered except none; mem_data is sampled only in RVEC/IVEC.

## Test plan
- Boot: rst 2 cycles, mem_data=0x40 in RVEC -> pc 00 (vec_fetch=1, valid=0), then 40, 41, 42 with valid=1.
- Call/ret: at pc=42, call with branch_addr=80 -> pc 80, ras_count=1. Two sequential cycles -> 82. ret -> pc 43, ras_count=0.
- Interrupt: at pc=50 with irq=1 -> pc 01 vec_fetch; mem_data=C0 -> pc C0, int_active=1. irq during handler -> pending. rti -> pc 50, int_active=0. Next edge -> pc 01 (pending interrupt taken, 50 pushed).
- Simultaneous events: at pc=60, irq=1 and branch_taken=1 to 90 -> pc 90, irq_pending=1. Next edge -> pc 01 with 90 pushed.
- RAS limits (depth 4): 5 nested calls -> ras_count=4, ras_ovf=1. 5 rets -> four correct returns, fifth sets ras_unf=1 and pc=pc+1.
- Stall/reset: stall held 2 cycles in IVEC -> pc stays 01. Releasing it -> vector loaded. rst asserted in IVEC with ras_count=2 -> pc 00, RVEC, ras_count=0, flags and int_active cleared. Wrap: pc=FF sequential -> 00.
